// File: rtl/count_snapshot_fifo_if.sv
// Snapshot FIFO port bundle.
// The counter feed, the capture request and the drain handshake share one interface.
interface count_snapshot_fifo_if #(
   parameter int unsigned CNT_WIDTH = 24,
   parameter int unsigned DEPTH     = 8
);
   logic [CNT_WIDTH-1:0]     Count;
   logic                     CountValid;
   logic                     Capture;
   logic                     SnapValid;
   logic                     SnapReady;
   logic [CNT_WIDTH-1:0]     SnapCount;
   logic [CNT_WIDTH-1:0]     SnapDelta;
   logic [$clog2(DEPTH):0]   Level;
   logic                     Overflow;
   logic [7:0]               DropCount;

   modport master (
      output Count, CountValid, Capture, SnapReady,
      input  SnapValid, SnapCount, SnapDelta, Level, Overflow, DropCount
   );

   modport slave (
      input  Count, CountValid, Capture, SnapReady,
      output SnapValid, SnapCount, SnapDelta, Level, Overflow, DropCount
   );
endinterface

// File: rtl/count_snapshot_fifo.sv
// Captures {count, delta-since-last-capture} into a circular FIFO on a strobe or periodic tick.
// Lost captures (counter not driving, or FIFO full without a same-cycle pop) are counted.
module count_snapshot_fifo #(
   parameter int unsigned CNT_WIDTH   = 24,
   parameter int unsigned DEPTH       = 8,
   parameter int unsigned AUTO_PERIOD = 0
) (
   input logic                  Clock,
   input logic                  Reset,
   count_snapshot_fifo_if.slave snap
);
   localparam int unsigned AW   = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   logic [CNT_WIDTH-1:0] mem_count [DEPTH];
   logic [CNT_WIDTH-1:0] mem_delta [DEPTH];
   logic [AW-1:0]        rd_ptr;
   logic [AW-1:0]        wr_ptr;
   logic [AW:0]          level;
   logic [CNT_WIDTH-1:0] last_count;
   logic                 overflow;
   logic [7:0]           drop_count;

   logic tick;
   logic req;
   logic pop;
   logic push;
   logic full;
   logic drop_invalid;
   logic drop_full;

   generate
      if (AUTO_PERIOD > 0) begin : g_tick
         localparam int unsigned PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
         logic [PW-1:0] period_cnt;

         always_ff @(posedge Clock) begin
            if (Reset)     period_cnt <= '0;
            else if (tick) period_cnt <= '0;
            else           period_cnt <= period_cnt + 1'b1;
         end

         assign tick = (period_cnt == PW'(AUTO_PERIOD - 1));
      end else begin : g_no_tick
         assign tick = 1'b0;
      end
   endgenerate

   always_comb begin
      full         = (level == FULL);
      pop          = (level != '0) & snap.SnapReady;
      req          = snap.Capture | tick;
      // A pop on the same edge frees the slot the push needs, so full-with-pop still accepts.
      push         = req & snap.CountValid & (~full | pop);
      drop_invalid = req & ~snap.CountValid;
      drop_full    = req & snap.CountValid & full & ~pop;
   end

   always_ff @(posedge Clock) begin
      if (push && !Reset) begin
         mem_count[wr_ptr] <= snap.Count;
         mem_delta[wr_ptr] <= snap.Count - last_count;
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         level      <= '0;
         last_count <= '0;
         overflow   <= 1'b0;
         drop_count <= '0;
      end else begin
         if (push) begin
            wr_ptr     <= wr_ptr + 1'b1;
            last_count <= snap.Count;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      level <= level + 1'b1;
         else if (pop && !push) level <= level - 1'b1;
         if (drop_full) overflow <= 1'b1;
         if ((drop_invalid || drop_full) && drop_count != 8'hFF)
            drop_count <= drop_count + 1'b1;
      end
   end

   always_comb begin
      snap.SnapValid = (level != '0);
      snap.SnapCount = snap.SnapValid ? mem_count[rd_ptr] : '0;
      snap.SnapDelta = snap.SnapValid ? mem_delta[rd_ptr] : '0;
      snap.Level     = level;
      snap.Overflow  = overflow;
      snap.DropCount = drop_count;
   end
endmodule

// File: tb/tb_count_snapshot_fifo.sv
// Directed bench: dut_a has periodic capture disabled, dut_b ticks every 16 cycles.
module tb_count_snapshot_fifo;
   logic Clock = 1'b0;
   logic Reset;
   int   checks = 0;
   int   passes = 0;

   always #5 Clock = ~Clock;

   count_snapshot_fifo_if #(.CNT_WIDTH(24), .DEPTH(8)) ifa ();
   count_snapshot_fifo_if #(.CNT_WIDTH(24), .DEPTH(8)) ifb ();

   count_snapshot_fifo #(.CNT_WIDTH(24), .DEPTH(8), .AUTO_PERIOD(0)) dut_a (
      .Clock(Clock), .Reset(Reset), .snap(ifa)
   );
   count_snapshot_fifo #(.CNT_WIDTH(24), .DEPTH(8), .AUTO_PERIOD(16)) dut_b (
      .Clock(Clock), .Reset(Reset), .snap(ifb)
   );

   task automatic step();
      @(posedge Clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic check_reset_a(input string tag);
      check({tag, "_level"}, 32'(ifa.Level), 0);
      check({tag, "_valid"}, 32'(ifa.SnapValid), 0);
      check({tag, "_count"}, 32'(ifa.SnapCount), 0);
      check({tag, "_delta"}, 32'(ifa.SnapDelta), 0);
      check({tag, "_ovf"},   32'(ifa.Overflow), 0);
      check({tag, "_drops"}, 32'(ifa.DropCount), 0);
   endtask

   initial begin
      Reset          = 1'b1;
      ifa.Count      = '0;
      ifa.CountValid = 1'b0;
      ifa.Capture    = 1'b0;
      ifa.SnapReady  = 1'b0;
      ifb.Count      = '0;
      ifb.CountValid = 1'b0;
      ifb.Capture    = 1'b0;
      ifb.SnapReady  = 1'b0;

      step();
      check_reset_a("rst0");
      Reset = 1'b0;

      // single capture and drain
      ifa.Count = 24'd100; ifa.CountValid = 1'b1; ifa.Capture = 1'b1;
      step();
      ifa.Capture = 1'b0;
      check("t1_valid", 32'(ifa.SnapValid), 1);
      check("t1_count", 32'(ifa.SnapCount), 100);
      check("t1_delta", 32'(ifa.SnapDelta), 100);
      check("t1_level", 32'(ifa.Level), 1);
      ifa.SnapReady = 1'b1;
      step();
      ifa.SnapReady = 1'b0;
      check("t1_empty_level", 32'(ifa.Level), 0);
      check("t1_empty_valid", 32'(ifa.SnapValid), 0);
      check("t1_empty_count", 32'(ifa.SnapCount), 0);
      check("t1_empty_delta", 32'(ifa.SnapDelta), 0);

      // delta wraps modulo 2^24
      ifa.Count = 24'hFFFFFE; ifa.Capture = 1'b1;
      step();
      ifa.Count = 24'h000003;
      step();
      ifa.Capture = 1'b0;
      check("t2_level", 32'(ifa.Level), 2);
      check("t2_head_count", 32'(ifa.SnapCount), 32'hFFFFFE);
      check("t2_head_delta", 32'(ifa.SnapDelta), 32'hFFFF9A);
      ifa.SnapReady = 1'b1;
      step();
      check("t2_wrap_count", 32'(ifa.SnapCount), 3);
      check("t2_wrap_delta", 32'(ifa.SnapDelta), 5);
      step();
      ifa.SnapReady = 1'b0;
      check("t2_drained", 32'(ifa.Level), 0);

      // fill to DEPTH, ninth capture dropped
      ifa.Capture = 1'b1;
      for (int i = 0; i < 9; i++) begin
         ifa.Count = 24'(10 + i);
         step();
      end
      ifa.Capture = 1'b0;
      check("t3_full_level", 32'(ifa.Level), 8);
      check("t3_ovf", 32'(ifa.Overflow), 1);
      check("t3_drops", 32'(ifa.DropCount), 1);
      check("t3_head_count", 32'(ifa.SnapCount), 10);
      check("t3_head_delta", 32'(ifa.SnapDelta), 7);
      // capture while full with a same-cycle pop is accepted
      ifa.Count = 24'd40; ifa.Capture = 1'b1; ifa.SnapReady = 1'b1;
      step();
      ifa.Capture = 1'b0;
      check("t3_fullpop_level", 32'(ifa.Level), 8);
      check("t3_fullpop_drops", 32'(ifa.DropCount), 1);
      check("t3_fullpop_head", 32'(ifa.SnapCount), 11);
      check("t3_fullpop_hdelta", 32'(ifa.SnapDelta), 1);
      for (int i = 0; i < 7; i++) step();
      check("t3_tail_count", 32'(ifa.SnapCount), 40);
      check("t3_tail_delta", 32'(ifa.SnapDelta), 23);
      check("t3_tail_level", 32'(ifa.Level), 1);
      step();
      ifa.SnapReady = 1'b0;
      check("t3_drained", 32'(ifa.Level), 0);

      // capture while counter not driving
      ifa.CountValid = 1'b0; ifa.Count = 24'd999; ifa.Capture = 1'b1;
      step();
      check("t4_nopush", 32'(ifa.Level), 0);
      check("t4_drops", 32'(ifa.DropCount), 2);
      ifa.CountValid = 1'b1; ifa.Count = 24'd50;
      step();
      ifa.Capture = 1'b0;
      check("t4_count", 32'(ifa.SnapCount), 50);
      check("t4_delta", 32'(ifa.SnapDelta), 10);

      // build Level=5, DropCount=3, then reset with a capture pending
      ifa.CountValid = 1'b0; ifa.Capture = 1'b1;
      step();
      ifa.CountValid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         ifa.Count = 24'(60 + i);
         step();
      end
      check("t6_pre_level", 32'(ifa.Level), 5);
      check("t6_pre_drops", 32'(ifa.DropCount), 3);
      check("t6_pre_ovf", 32'(ifa.Overflow), 1);
      ifa.Count = 24'd77;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      ifa.Capture = 1'b0;
      check_reset_a("t6_rst");
      step();
      check("t6_post_level", 32'(ifa.Level), 0);
      ifa.Count = 24'd7; ifa.Capture = 1'b1;
      step();
      ifa.Capture = 1'b0;
      check("t6_lastcount_reset", 32'(ifa.SnapDelta), 7);

      // periodic capture on dut_b
      ifb.Count = 24'd500; ifb.CountValid = 1'b1; ifb.SnapReady = 1'b1;
      Reset = 1'b1;
      step();
      Reset = 1'b0;
      for (int k = 1; k <= 15; k++) step();
      check("t5_before_tick", 32'(ifb.Level), 0);
      step();
      check("t5_tick1_level", 32'(ifb.Level), 1);
      check("t5_tick1_count", 32'(ifb.SnapCount), 500);
      check("t5_tick1_delta", 32'(ifb.SnapDelta), 500);
      ifb.Count = 24'd600;
      step();
      check("t5_tick1_popped", 32'(ifb.Level), 0);
      for (int k = 18; k <= 32; k++) step();
      check("t5_tick2_level", 32'(ifb.Level), 1);
      check("t5_tick2_delta", 32'(ifb.SnapDelta), 100);
      step();
      ifb.SnapReady = 1'b0;
      for (int k = 34; k <= 47; k++) step();
      check("t5_idle", 32'(ifb.Level), 0);
      ifb.Count = 24'd650; ifb.Capture = 1'b1;
      step();
      ifb.Capture = 1'b0;
      check("t5_coinc_level", 32'(ifb.Level), 1);
      check("t5_coinc_count", 32'(ifb.SnapCount), 650);
      check("t5_coinc_delta", 32'(ifb.SnapDelta), 50);
      step();
      check("t5_coinc_single", 32'(ifb.Level), 1);
      check("t5_coinc_drops", 32'(ifb.DropCount), 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
